// File: rtl/vxc_row_fetch_pkg.sv
// Chunk geometry and fetch FSM encoding shared by the row fetcher and the
// complex vector-times-constant compute stage.
package vxc_row_fetch_pkg;

    localparam int unsigned VXC_NUM_EQ = 19;
    localparam int unsigned VXC_NI     = 8;
    localparam int unsigned VXC_ELEM_W = 64;
    localparam int unsigned VXC_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_PRESENT,
        ST_DONE
    } fetch_state_e;

    function automatic int unsigned num_chunks(input int unsigned n, input int unsigned ni);
        return (n + ni - 1) / ni;
    endfunction

endpackage

// File: rtl/vxc_lane_packer.sv
// NI lane registers for one row; read data lands in the lane that was issued
// one cycle earlier, and a clear zeroes every lane so untouched lanes read as padding.
module vxc_lane_packer
    import vxc_row_fetch_pkg::*;
#(
    parameter int unsigned NI     = VXC_NI,
    parameter int unsigned ELEM_W = VXC_ELEM_W,
    parameter int unsigned LW     = 4
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   issue_i,
    input  logic [LW-1:0]          issue_lane_i,
    input  logic [ELEM_W-1:0]      rdata_i,
    output logic [NI*ELEM_W-1:0]   lanes_o
);

    logic                 pend_q;
    logic [LW-1:0]        pend_lane_q;
    logic [NI*ELEM_W-1:0] lanes_q;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            pend_q      <= 1'b0;
            pend_lane_q <= '0;
            lanes_q     <= '0;
        end else begin
            pend_q      <= issue_i;
            pend_lane_q <= issue_lane_i;
            if (clear_i) begin
                lanes_q <= '0;
            end else if (pend_q) begin
                for (int unsigned j = 0; j < NI; j++) begin
                    if (pend_lane_q == LW'(j)) begin
                        lanes_q[j*ELEM_W +: ELEM_W] <= rdata_i;
                    end
                end
            end
        end
    end

    assign lanes_o = lanes_q;

endmodule

// File: rtl/vxc_row_fetch.sv
// Fetches both operand rows element-by-element, packs them into NI-lane chunks
// with zero padding, and hands each chunk pair to the compute stage via valid/ready.
module vxc_row_fetch
    import vxc_row_fetch_pkg::*;
#(
    parameter int unsigned NUM_EQ = VXC_NUM_EQ,
    parameter int unsigned NI     = VXC_NI,
    parameter int unsigned ELEM_W = VXC_ELEM_W,
    parameter int unsigned ADDR_W = VXC_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_a,
    input  logic [ADDR_W-1:0]     base_b,
    output logic                  mem_a_re,
    output logic                  mem_b_re,
    output logic [ADDR_W-1:0]     mem_a_addr,
    output logic [ADDR_W-1:0]     mem_b_addr,
    input  logic [ELEM_W-1:0]     mem_a_rdata,
    input  logic [ELEM_W-1:0]     mem_b_rdata,
    output logic [NI*ELEM_W-1:0]  first_row_plus_additional,
    output logic [NI*ELEM_W-1:0]  second_row_plus_additional,
    output logic                  chunk_valid,
    input  logic                  chunk_ready,
    output logic [31:0]           chunk_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CHUNKS = num_chunks(NUM_EQ, NI);
    localparam int unsigned LCW    = $clog2(NI + 2);

    fetch_state_e      state_q;
    logic [31:0]       chunk_cnt_q;
    logic [LCW-1:0]    lane_cnt_q;
    logic [ADDR_W-1:0] base_a_q, base_b_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic              re_q;
    logic [LCW-1:0]    re_lane_q;
    logic              chunk_valid_q, busy_q, done_q;

    logic              accept_d, last_chunk_d, fill_start_d, issue_d;
    logic [31:0]       issue_chunk_d, issue_k_d;
    logic [LCW-1:0]    issue_lane_d;
    logic [ADDR_W-1:0] issue_base_a_d, issue_base_b_d;

    // The lane issued on the edge that enters FILL is lane 0, so the
    // registered read strobe lines up with the cycle the state says FILL.
    always_comb begin
        accept_d       = (state_q == ST_PRESENT) && chunk_valid_q && chunk_ready;
        last_chunk_d   = (chunk_cnt_q == 32'(CHUNKS - 1));
        fill_start_d   = ((state_q == ST_IDLE) && start) || (accept_d && !last_chunk_d);
        issue_d        = fill_start_d || ((state_q == ST_FILL) && (lane_cnt_q < LCW'(NI)));
        issue_chunk_d  = chunk_cnt_q;
        if (state_q == ST_IDLE) begin
            issue_chunk_d = '0;
        end else if (accept_d) begin
            issue_chunk_d = chunk_cnt_q + 32'd1;
        end
        issue_lane_d   = fill_start_d ? '0 : lane_cnt_q;
        issue_k_d      = issue_chunk_d * NI + 32'(issue_lane_d);
        issue_base_a_d = (state_q == ST_IDLE) ? base_a : base_a_q;
        issue_base_b_d = (state_q == ST_IDLE) ? base_b : base_b_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            chunk_cnt_q   <= '0;
            lane_cnt_q    <= '0;
            base_a_q      <= '0;
            base_b_q      <= '0;
            addr_a_q      <= '0;
            addr_b_q      <= '0;
            re_q          <= 1'b0;
            re_lane_q     <= '0;
            chunk_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            re_q   <= 1'b0;
            done_q <= 1'b0;
            if (issue_d) begin
                re_lane_q <= issue_lane_d;
                if (issue_k_d < NUM_EQ) begin
                    re_q     <= 1'b1;
                    addr_a_q <= issue_base_a_d + issue_k_d[ADDR_W-1:0];
                    addr_b_q <= issue_base_b_d + issue_k_d[ADDR_W-1:0];
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_a_q    <= base_a;
                        base_b_q    <= base_b;
                        chunk_cnt_q <= '0;
                        lane_cnt_q  <= LCW'(1);
                        busy_q      <= 1'b1;
                        state_q     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (lane_cnt_q == LCW'(NI + 1)) begin
                        chunk_valid_q <= 1'b1;
                        state_q       <= ST_PRESENT;
                    end else begin
                        lane_cnt_q <= lane_cnt_q + LCW'(1);
                    end
                end
                ST_PRESENT: begin
                    if (accept_d) begin
                        chunk_valid_q <= 1'b0;
                        if (last_chunk_d) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            chunk_cnt_q <= chunk_cnt_q + 32'd1;
                            lane_cnt_q  <= LCW'(1);
                            state_q     <= ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    vxc_lane_packer #(.NI(NI), .ELEM_W(ELEM_W), .LW(LCW)) u_pack_a (
        .clk          (clk),
        .rst_ni       (reset),
        .clear_i      (fill_start_d),
        .issue_i      (re_q),
        .issue_lane_i (re_lane_q),
        .rdata_i      (mem_a_rdata),
        .lanes_o      (first_row_plus_additional)
    );

    vxc_lane_packer #(.NI(NI), .ELEM_W(ELEM_W), .LW(LCW)) u_pack_b (
        .clk          (clk),
        .rst_ni       (reset),
        .clear_i      (fill_start_d),
        .issue_i      (re_q),
        .issue_lane_i (re_lane_q),
        .rdata_i      (mem_b_rdata),
        .lanes_o      (second_row_plus_additional)
    );

    assign mem_a_re    = re_q;
    assign mem_b_re    = re_q;
    assign mem_a_addr  = addr_a_q;
    assign mem_b_addr  = addr_b_q;
    assign chunk_valid = chunk_valid_q;
    assign chunk_idx   = chunk_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_vxc_row_fetch.sv
// Bench for vxc_row_fetch: two instances (19 and 16 equations) checked against
// a per-element memory model of what each chunk lane and each read should be.
module tb_vxc_row_fetch;

    localparam int NI = 8;
    localparam int EW = 64;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] base_a, base_b;
    logic          start0, start1, ready0, ready1;
    logic          re_a0, re_b0, re_a1, re_b1;
    logic [AW-1:0] ad_a0, ad_b0, ad_a1, ad_b1;
    logic [EW-1:0] rd_a0 = '0, rd_b0 = '0, rd_a1 = '0, rd_b1 = '0;
    logic [NI*EW-1:0] fa0, fb0, fa1, fb1;
    logic          v0, v1, busy0, busy1, done0, done1;
    logic [31:0]   idx0, idx1;

    logic [EW-1:0] mem_a [1024];
    logic [EW-1:0] mem_b [1024];

    int errors = 0;
    int checks = 0;
    int sel = 0;

    vxc_row_fetch #(.NUM_EQ(19), .NI(NI), .ELEM_W(EW), .ADDR_W(AW)) u_dut19 (
        .clk(clk), .reset(reset), .start(start0), .base_a(base_a), .base_b(base_b),
        .mem_a_re(re_a0), .mem_b_re(re_b0), .mem_a_addr(ad_a0), .mem_b_addr(ad_b0),
        .mem_a_rdata(rd_a0), .mem_b_rdata(rd_b0),
        .first_row_plus_additional(fa0), .second_row_plus_additional(fb0),
        .chunk_valid(v0), .chunk_ready(ready0), .chunk_idx(idx0), .busy(busy0), .done(done0)
    );

    vxc_row_fetch #(.NUM_EQ(16), .NI(NI), .ELEM_W(EW), .ADDR_W(AW)) u_dut16 (
        .clk(clk), .reset(reset), .start(start1), .base_a(base_a), .base_b(base_b),
        .mem_a_re(re_a1), .mem_b_re(re_b1), .mem_a_addr(ad_a1), .mem_b_addr(ad_b1),
        .mem_a_rdata(rd_a1), .mem_b_rdata(rd_b1),
        .first_row_plus_additional(fa1), .second_row_plus_additional(fb1),
        .chunk_valid(v1), .chunk_ready(ready1), .chunk_idx(idx1), .busy(busy1), .done(done1)
    );

    // Single-port memories: data valid exactly one cycle after the read enable.
    always @(posedge clk) begin
        if (re_a0) rd_a0 <= mem_a[ad_a0];
        if (re_b0) rd_b0 <= mem_b[ad_b0];
        if (re_a1) rd_a1 <= mem_a[ad_a1];
        if (re_b1) rd_b1 <= mem_b[ad_b1];
    end

    logic          o_re_a, o_re_b, o_valid, o_busy, o_done;
    logic [AW-1:0] o_ad_a, o_ad_b;
    logic [NI*EW-1:0] o_fa, o_fb;
    logic [31:0]   o_idx;

    always_comb begin
        o_re_a  = (sel != 0) ? re_a1 : re_a0;
        o_re_b  = (sel != 0) ? re_b1 : re_b0;
        o_ad_a  = (sel != 0) ? ad_a1 : ad_a0;
        o_ad_b  = (sel != 0) ? ad_b1 : ad_b0;
        o_fa    = (sel != 0) ? fa1 : fa0;
        o_fb    = (sel != 0) ? fb1 : fb0;
        o_valid = (sel != 0) ? v1 : v0;
        o_idx   = (sel != 0) ? idx1 : idx0;
        o_busy  = (sel != 0) ? busy1 : busy0;
        o_done  = (sel != 0) ? done1 : done0;
    end

    logic [AW-1:0] log_a [$];
    logic [AW-1:0] log_b [$];
    int lock_bad = 0;
    int log_start = 0;
    int lock_start = 0;

    always @(posedge clk) begin
        if (o_re_a) log_a.push_back(o_ad_a);
        if (o_re_b) log_b.push_back(o_ad_b);
        if (o_re_a !== o_re_b) lock_bad++;
    end

    function automatic logic [EW-1:0] exp_lane(input int ne, input logic [AW-1:0] base,
                                               input int c, input int j, input bit row_b);
        int k;
        int a;
        k = c * NI + j;
        if (k >= ne) return '0;
        a = (int'(base) + k) % 1024;
        return row_b ? mem_b[a] : mem_a[a];
    endfunction

    task automatic set_start(input logic v);
        if (sel != 0) start1 = v; else start0 = v;
    endtask

    task automatic set_ready(input logic v);
        if (sel != 0) ready1 = v; else ready0 = v;
    endtask

    task automatic launch(input logic [AW-1:0] ba, input logic [AW-1:0] bb);
        @(negedge clk);
        base_a = ba;
        base_b = bb;
        set_start(1'b1);
        log_start = log_a.size();
        lock_start = lock_bad;
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got %b want 1", o_busy);
        end
    endtask

    task automatic collect(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input int hold_chunk, input int hold_cycles,
                           input bit poke, input bit stop_at_done);
        int ne;
        int nch;
        int n;
        int bad;
        int ea;
        int eb;
        logic [NI*EW-1:0] exp_a, exp_b;
        ne  = (sel != 0) ? 16 : 19;
        nch = (ne + NI - 1) / NI;
        for (int c = 0; c < nch; c++) begin
            n = 0;
            if (c == hold_chunk) set_ready(1'b0);
            while (o_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != NI + 1) begin
                errors++;
                $display("FAIL valid_latency chunk %0d: got %0d edges want %0d", c, n, NI + 1);
                if (n >= 50) return;
            end
            for (int j = 0; j < NI; j++) begin
                exp_a[j*EW +: EW] = exp_lane(ne, ba, c, j, 1'b0);
                exp_b[j*EW +: EW] = exp_lane(ne, bb, c, j, 1'b1);
            end
            checks++;
            if (o_idx !== 32'(c)) begin
                errors++;
                $display("FAIL chunk_idx: got %0d want %0d", o_idx, c);
            end
            for (int j = 0; j < NI; j++) begin
                checks++;
                if (o_fa[j*EW +: EW] !== exp_a[j*EW +: EW] || o_fb[j*EW +: EW] !== exp_b[j*EW +: EW]) begin
                    errors++;
                    $display("FAIL lane c%0d l%0d: got a=%h b=%h want a=%h b=%h", c, j,
                             o_fa[j*EW +: EW], o_fb[j*EW +: EW], exp_a[j*EW +: EW], exp_b[j*EW +: EW]);
                end
            end
            if (c == hold_chunk) begin
                for (int h = 0; h < hold_cycles; h++) begin
                    @(negedge clk);
                    checks++;
                    if (o_valid !== 1'b1 || o_idx !== 32'(c) || o_fa !== exp_a || o_fb !== exp_b ||
                        o_re_a !== 1'b0 || o_re_b !== 1'b0) begin
                        errors++;
                        $display("FAIL hold cycle %0d: got valid=%b idx=%0d re=%b%b a_ok=%b b_ok=%b want 1 %0d 00 1 1",
                                 h, o_valid, o_idx, o_re_a, o_re_b, o_fa === exp_a, o_fb === exp_b, c);
                    end
                end
                set_ready(1'b1);
            end
            if (poke && c == 1) begin
                set_start(1'b1);
                base_a = ~ba;
                base_b = ~bb;
            end
            @(posedge clk);
            @(negedge clk);
            set_start(1'b0);
            base_a = ba;
            base_b = bb;
        end
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b valid=%b want 1 1 0", o_done, o_busy, o_valid);
        end
        bad = 0;
        if (log_a.size() - log_start != ne || log_b.size() - log_start != ne) begin
            bad = 1000;
        end else begin
            for (int k = 0; k < ne; k++) begin
                ea = (int'(ba) + k) % 1024;
                eb = (int'(bb) + k) % 1024;
                if (log_a[log_start + k] !== AW'(ea) || log_b[log_start + k] !== AW'(eb)) bad++;
            end
        end
        checks++;
        if (bad != 0 || lock_bad != lock_start) begin
            errors++;
            $display("FAIL read_seq: got reads=%0d/%0d bad=%0d lockstep_err=%0d want reads=%0d bad=0 lockstep_err=0",
                     log_a.size() - log_start, log_b.size() - log_start, bad, lock_bad - lock_start, ne);
        end
        if (stop_at_done) return;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_fall: got done=%b busy=%b want 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++;
            if ({o_re_a, o_re_b, o_valid, o_busy, o_done} !== 5'b0 || o_ad_a !== '0 || o_ad_b !== '0 ||
                o_fa !== '0 || o_fb !== '0 || o_idx !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got re=%b%b v=%b busy=%b done=%b addr=%0d/%0d idx=%0d want all 0",
                         s, o_re_a, o_re_b, o_valid, o_busy, o_done, o_ad_a, o_ad_b, o_idx);
            end
        end
        sel = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        sel = 0;
        launch(10'd0, 10'd0);
        collect(10'd0, 10'd0, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_two_chunks;
        logic [AW-1:0] ba, bb;
        sel = 1;
        ba = AW'($urandom_range(0, 1023));
        bb = AW'($urandom_range(0, 1023));
        launch(ba, bb);
        collect(ba, bb, -1, 0, 1'b0, 1'b0);
        sel = 0;
    endtask

    task automatic test_backpressure;
        logic [AW-1:0] ba, bb;
        sel = 0;
        ba = AW'($urandom_range(0, 1023));
        bb = AW'($urandom_range(0, 1023));
        launch(ba, bb);
        collect(ba, bb, 1, 20, 1'b0, 1'b0);
    endtask

    task automatic test_wrap;
        sel = 0;
        launch(10'd1020, 10'd1015);
        collect(10'd1020, 10'd1015, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        int n;
        logic [AW-1:0] ba, bb;
        sel = 0;
        launch(10'd100, 10'd200);
        n = 0;
        while (!(o_idx === 32'd1 && o_valid === 1'b0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL reach_chunk1: got idx=%0d after %0d cycles want 1", o_idx, n);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_re_a, o_re_b, o_valid, o_busy, o_done} !== 5'b0 || o_ad_a !== '0 || o_ad_b !== '0 ||
            o_fa !== '0 || o_fb !== '0 || o_idx !== '0) begin
            errors++;
            $display("FAIL reset_mid: got re=%b%b v=%b busy=%b done=%b addr=%0d/%0d idx=%0d want all 0",
                     o_re_a, o_re_b, o_valid, o_busy, o_done, o_ad_a, o_ad_b, o_idx);
        end
        reset = 1'b1;
        ba = AW'($urandom_range(0, 1023));
        bb = AW'($urandom_range(0, 1023));
        launch(ba, bb);
        collect(ba, bb, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_at_done;
        logic [AW-1:0] ba, bb, ba2, bb2;
        sel = 0;
        ba  = AW'($urandom_range(0, 1023));
        bb  = AW'($urandom_range(0, 1023));
        ba2 = AW'($urandom_range(0, 1023));
        bb2 = AW'($urandom_range(0, 1023));
        launch(ba, bb);
        collect(ba, bb, -1, 0, 1'b1, 1'b1);
        base_a = ba2;
        base_b = bb2;
        set_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got busy=%b done=%b want 0 0", o_busy, o_done);
        end
        log_start = log_a.size();
        lock_start = lock_bad;
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_after_done: got busy=%b want 1", o_busy);
        end
        collect(ba2, bb2, -1, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        ready0 = 1'b1;
        ready1 = 1'b1;
        base_a = '0;
        base_b = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = EW'(i + 1);
            mem_b[i] = EW'(i + 1);
        end
        test_reset;
        test_basic;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = {$urandom, $urandom};
            mem_b[i] = {$urandom, $urandom};
        end
        test_two_chunks;
        test_backpressure;
        test_wrap;
        test_reset_mid;
        test_start_at_done;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/vxc_row_fetch.md
# vxc_row_fetch

Upstream feeder for the complex vector-times-constant add/sub stage. Reads the two operand vectors (first row, second row) element-by-element from two single-port element memories, packs them into NI-lane chunks, zero-pads the lanes past the last equation, and presents each chunk pair with a valid/ready handshake to the compute stage. One fetch per `start`; `done` pulses after the last chunk is accepted.

## Interface
- `NUM_EQ`, 19, equations (vector elements) per cluster
- `NI`, 8, lanes per chunk (matches compute stage `no_of_units`)
- `ELEM_W`, 64, complex element width (re/im packed)
- `ADDR_W`, 10, element memory address width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  begin a fetch; sampled only in IDLE
- `base_a` / `base_b`  in  ADDR_W  first/second row base addresses, captured with `start`
- `mem_a_re` / `mem_b_re`  out  1  read enables
- `mem_a_addr` / `mem_b_addr`  out  ADDR_W  read addresses
- `mem_a_rdata` / `mem_b_rdata`  in  ELEM_W  read data, valid exactly 1 cycle after `re`
- `first_row_plus_additional`  out  NI*ELEM_W  chunk A; lane j at bits [j*ELEM_W +: ELEM_W]
- `second_row_plus_additional`  out  NI*ELEM_W  chunk B, same layout
- `chunk_valid`  out  1  chunk pair stable and valid
- `chunk_ready`  in  1  compute stage accepts chunk
- `chunk_idx`  out  32  index of presented chunk
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse after last chunk accepted

## Operation
- CHUNKS = ceil(NUM_EQ/NI) (19/8 -> 3). When NUM_EQ is a multiple of NI, no all-padding chunk is produced.
- States: IDLE, FILL, PRESENT, DONE.
- IDLE: `start`=1 -> capture bases, chunk_cnt=0, lane_cnt=0 -> FILL. `start` outside IDLE ignored.
- FILL: one lane per cycle, lane_cnt 0..NI-1; element k = chunk_cnt*NI + lane_cnt. If k < NUM_EQ: both `re`=1, addr = base + k (mod 2^ADDR_W). If k >= NUM_EQ: `re`=0, lane register loaded with zero. Returning data written to its lane one cycle later. After lane NI-1 issued, one drain cycle, then PRESENT.
- PRESENT: `chunk_valid`=1; both chunk buses and `chunk_idx` held constant until `chunk_valid && chunk_ready` at an edge. On acceptance: if chunk_cnt = CHUNKS-1 -> DONE, else chunk_cnt+1, lane_cnt=0 -> FILL.
- DONE: `done`=1 for one cycle -> IDLE.
- Both memories read in lockstep; never more than one read per memory per cycle.
- Lane registers cleared at the start of each FILL, so padding lanes are always zero.

## Timing
- Reset (reset=0 at an edge): state IDLE; all outputs 0 (`re`, addresses, chunk buses, `chunk_valid`, `chunk_idx`, `busy`, `done`); counters 0. Applies mid-fetch; in-flight read data discarded.
- `busy` rises the edge after `start` is sampled.
- `chunk_valid` rises NI+1 edges after the edge sampling `start` (9 for NI=8); same gap from an accepting edge to the next chunk's `chunk_valid`.
- `chunk_ready` high while `chunk_valid` low has no effect.
- `chunk_ready` held high: chunk period NI+2 cycles (NI fill + 1 drain + 1 present).
- `done` asserts the cycle after the last acceptance; `busy` falls with `done`'s fall. `start` in the same cycle as `done` ignored; accepted the next cycle.

## Structure
- Shared package: `NUM_EQ`, `NI`, `ELEM_W`, CHUNKS function (ceil divide), FSM state enum; also consumed by the compute stage so chunk geometry stays consistent.
- One sub-module: `vxc_lane_packer` (NI lane registers, clear, write-lane-j with 1-cycle data alignment), instantiated once per row.

## Test plan
- NUM_EQ=19, NI=8, mem[i]=i+1 for both rows, ready tied high -> 3 chunks; chunk 2 lanes 0-2 = 17,18,19, lanes 3-7 = 0; no `re` for k>=19; `done` once.
- NUM_EQ=16, NI=8 -> exactly 2 chunks, no padding chunk, `chunk_idx` 0,1.
- Backpressure: hold `chunk_ready`=0 for 20 cycles on chunk 1 -> buses, `chunk_valid`, `chunk_idx` unchanged; no memory reads issued while held.
- base_a=1020, ADDR_W=10 -> addresses 1020..1023,0,1,... wrap; data matches.
- reset=0 mid-FILL of chunk 1 -> next edge all outputs 0, IDLE; fresh `start` yields chunk 0 correctly.
- `start` pulsed while busy and in same cycle as `done` -> ignored; `start` next cycle -> new fetch from new bases.
